// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator on the pixel clock.
// Waits for a stable PLL lock, then counts the full raster.
// hsync, vsync, de, x, y, frame_start and running come from one output register.
// That register adds one cycle of latency after the raster counters.
module vga_timing_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_SETTLE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = $clog2(LOCK_SETTLE + 1);

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [SW-1:0] SETTLE_DONE = SW'(LOCK_SETTLE);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [11:0]   h_cnt_reg, h_cnt_next;
  logic [11:0]   v_cnt_reg, v_cnt_next;
  logic [1:0]    lk_sync_reg;
  logic          lk_s;
  logic          run_dec;

  assign lk_s = lk_sync_reg[1];

  // Two-flop synchronizer bringing the PLL lock flag into the pixel domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lk_sync_reg <= 2'b00;
    else     lk_sync_reg <= {lk_sync_reg[0], pll_locked};
  end

  // State, settle counter and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= WAIT_LOCK;
      settle_reg <= '0;
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      h_cnt_reg  <= h_cnt_next;
      v_cnt_reg  <= v_cnt_next;
    end
  end

  // Next-state logic: lock qualification, then free-running raster counters.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    h_cnt_next  = '0;
    v_cnt_next  = '0;
    case (state_reg)
      WAIT_LOCK: begin
        settle_next = '0;
        if (lk_s) begin
          state_next  = SETTLE;
          settle_next = SW'(1);
        end
      end
      SETTLE: begin
        if (!lk_s) begin
          state_next  = WAIT_LOCK;
          settle_next = '0;
        end else if (settle_reg == SETTLE_DONE) begin
          // Counters are already zero here, so the raster starts at 0,0.
          state_next  = RUN;
          settle_next = '0;
        end else begin
          settle_next = settle_reg + SW'(1);
        end
      end
      RUN: begin
        if (!lk_s) begin
          // Lock lost: drop straight back to idle, no partial-line resume.
          state_next = WAIT_LOCK;
        end else if (h_cnt_reg == H_LAST) begin
          h_cnt_next = '0;
          v_cnt_next = (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
        end else begin
          h_cnt_next = h_cnt_reg + 12'd1;
          v_cnt_next = v_cnt_reg;
        end
      end
      default: begin
        state_next  = WAIT_LOCK;
        settle_next = '0;
      end
    endcase
  end

  // Decode is only valid while running with lock still present.
  // A lock drop therefore shows idle outputs on the very next cycle.
  assign run_dec = (state_reg == RUN) && lk_s;

  // Output register: raster decode when running, idle levels otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else if (run_dec) begin
      de          <= (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
      hsync       <= ((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END)) ? SYNC_POL : ~SYNC_POL;
      x           <= h_cnt_reg;
      y           <= v_cnt_reg;
      frame_start <= (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
      running     <= 1'b1;
    end else begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a scaled-down raster so whole frames fit a short run.
// Expected outputs are modelled from the lock streak: the count of consecutive cycles lock has been seen.
// The run position comes from that count by plain division.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;   // H_TOTAL = 30
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;   // V_TOTAL = 17
  localparam int LS = 20;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;                   // 510

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pll_locked = 1'b0;
  logic        hsync, vsync, de, frame_start, running;
  logic [11:0] x, y;

  int tests = 0;
  int fails = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .LOCK_SETTLE(LS)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  // Model: lock seen two edges ago (synchronizer delay), and how long it has stayed high.
  logic m_l1 = 1'b0, m_l2 = 1'b0;
  int   m_streak = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_l1 <= 1'b0; m_l2 <= 1'b0; m_streak <= 0;
    end else begin
      m_l1 <= pll_locked;
      m_l2 <= m_l1;
      m_streak <= m_l2 ? m_streak + 1 : 0;
    end
  end

  // Lock has to be seen for LS+1 qualifying edges before counting starts.
  // The output register then adds one more cycle, so pixel 0 appears at streak LS+2.
  task automatic model_expect(output logic e_hs, output logic e_vs, output logic e_de,
                              output int e_x, output int e_y, output logic e_fs, output logic e_run);
    int p, px, py;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_x = 0; e_y = 0; e_fs = 1'b0; e_run = 1'b0;
    if (m_streak >= LS + 2) begin
      p  = (m_streak - (LS + 2)) % FRAME;
      px = p % HT;
      py = p / HT;
      e_x = px; e_y = py; e_run = 1'b1;
      e_de = (px < HA) && (py < VA);
      e_hs = !((px >= HA + HF) && (px < HA + HF + HS));
      e_vs = !((py >= VA + VF) && (py < VA + VF + VS));
      e_fs = (p == 0);
    end
  endtask

  // Advance one cycle and compare every output with the model on the falling edge.
  task automatic tick();
    logic e_hs, e_vs, e_de, e_fs, e_run;
    int e_x, e_y;
    @(negedge clk);
    model_expect(e_hs, e_vs, e_de, e_x, e_y, e_fs, e_run);
    tests++;
    if (hsync !== e_hs || vsync !== e_vs || de !== e_de || int'(x) != e_x ||
        int'(y) != e_y || frame_start !== e_fs || running !== e_run) begin
      fails++;
      if (fails < 30)
        $display("FAIL model t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b run=%b want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b run=%b",
                 $time, hsync, vsync, de, x, y, frame_start, running,
                 e_hs, e_vs, e_de, e_x, e_y, e_fs, e_run);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  // Count ticks until running rises; returns -1 if the bound expires.
  task automatic wait_running(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (running === 1'b1) begin n = i; break; end
    end
  endtask

  initial begin
    int n, de_cnt, hs_cnt, hs_bad, vs_cnt, fs_cnt, found;

    // Reset pulse, then lock held low: outputs stay idle.
    rst = 1'b1;
    #1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    check("idle_running", int'(running), 0);
    check("idle_hsync", int'(hsync), 1);
    check("idle_vsync", int'(vsync), 1);
    check("idle_de", int'(de), 0);

    // Lock rises: running appears after 2 sync + LS settle + 1 state + 1 register cycles.
    pll_locked = 1'b1;
    wait_running(200, n);
    check("lock_to_running", n, LS + 4);
    check("first_x", int'(x), 0);
    check("first_y", int'(y), 0);
    check("first_de", int'(de), 1);
    check("first_fs", int'(frame_start), 1);

    // One full frame starting at pixel 0.
    de_cnt = 0; hs_cnt = 0; hs_bad = 0; vs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (de) de_cnt++;
      if (!hsync) begin
        hs_cnt++;
        if (x < 12'(HA + HF) || x > 12'(HA + HF + HS - 1)) hs_bad++;
      end
      if (!vsync) vs_cnt++;
      if (frame_start) fs_cnt++;
      if (de && y >= 12'(VA)) hs_bad++;
      tick();
    end
    check("frame_de_cycles", de_cnt, 160);
    check("frame_hsync_low", hs_cnt, 102);
    check("hsync_or_de_outside_window", hs_bad, 0);
    check("frame_vsync_low", vs_cnt, 60);
    check("frame_fs_count", fs_cnt, 1);
    check("frame_period_fs", int'(frame_start), 1);

    // Drop lock at x=10, y=5: outputs go idle three cycles later.
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (x == 12'd10 && y == 12'd5) begin found = 1; break; end
      tick();
    end
    check("found_drop_point", found, 1);
    pll_locked = 1'b0;
    tick(); tick();
    check("drop_running_after_2", int'(running), 1);
    tick();
    check("drop_running_after_3", int'(running), 0);
    check("drop_hsync_after_3", int'(hsync), 1);
    check("drop_x_after_3", int'(x), 0);
    for (int i = 0; i < 10; i++) tick();

    // Re-lock with a 3-cycle glitch mid-settle: the full settle restarts from the re-rise.
    pll_locked = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("glitch_still_idle", int'(running), 0);
    pll_locked = 1'b0;
    tick(); tick(); tick();
    pll_locked = 1'b1;
    wait_running(200, n);
    check("relock_to_running", n, LS + 4);
    check("relock_x", int'(x), 0);
    check("relock_y", int'(y), 0);
    check("relock_fs", int'(frame_start), 1);

    // Async reset mid-frame: outputs clear without waiting for a clock edge.
    for (int i = 0; i < 77; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_running", int'(running), 0);
    check("async_rst_de", int'(de), 0);
    check("async_rst_x", int'(x), 0);
    check("async_rst_hsync", int'(hsync), 1);
    tick(); tick();
    rst = 1'b0;
    // Lock is still high, so the settle repeats after reset.
    wait_running(200, n);
    check("post_rst_to_running", n, LS + 4);
    for (int i = 0; i < 40; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
